// File: rtl/mac_link_initiator.sv
// mac_link_initiator: UART-side initiator that streams operand pairs (A then B)
// through the transmitter, waits for the one-byte response of the MAC responder
// and compares it with a local 48-bit accumulator model.
// Optional build macro: MAC_LINK_STOP_ON_ERROR_EN -- when defined, the first
// mismatch or timeout ends the run; otherwise every pair runs and errors add up.
module mac_link_initiator #(
    parameter int unsigned NUM_PAIRS      = 16,
    parameter logic [7:0]  A_SEED         = 8'd1,
    parameter logic [7:0]  A_STEP         = 8'd1,
    parameter logic [7:0]  B_SEED         = 8'd2,
    parameter logic [7:0]  B_STEP         = 8'd3,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       tx_start_transmission,
    input  logic       tx_busy,
    output logic [7:0] tx_data_in,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] error_count,
    output logic       timeout_seen
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_A,
        S_GUARD_A,
        S_WAIT_A,
        S_LOAD_B,
        S_GUARD_B,
        S_WAIT_B,
        S_WAIT_RSP,
        S_CHECK,
        S_NEXT,
        S_DONE
    } state_t;

`ifdef MAC_LINK_STOP_ON_ERROR_EN
    localparam bit STOP_ON_ERROR = 1'b1;
`else
    localparam bit STOP_ON_ERROR = 1'b0;
`endif

    localparam logic [7:0]  LAST_IDX  = 8'(NUM_PAIRS - 1);
    localparam logic [31:0] TIMER_MAX = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_idx;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [47:0] r_acc;
    logic [31:0] r_timer;
    logic [7:0]  r_rsp;
    logic [7:0]  r_err;
    logic        r_tog;
    logic [7:0]  r_tx_data;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;

    logic [15:0] w_product;
    logic        w_timeout;
    logic        w_mismatch;
    logic        w_last;

    // Error counter saturates at 255 rather than wrapping back to a "clean" 0.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_product  = {8'd0, r_a} * {8'd0, r_b};
    assign w_timeout  = (r_timer == TIMER_MAX);
    // The expected response is the accumulator before the current pair is added.
    assign w_mismatch = (r_rsp != r_acc[7:0]);
    assign w_last     = (r_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples
        // pre-edge values; blocking here would create order-dependent races.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: byte A, byte B, wait for response, check, advance.
    always_comb begin
        // NOTE: default assigned first so every path drives w_state_next and no
        // latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                if (!tx_busy) w_state_next = S_GUARD_A;
            end
            S_GUARD_A: w_state_next = S_WAIT_A;
            S_WAIT_A: begin
                if (!tx_busy) w_state_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                if (!tx_busy) w_state_next = S_GUARD_B;
            end
            S_GUARD_B: w_state_next = S_WAIT_B;
            S_WAIT_B: begin
                if (!tx_busy) w_state_next = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (rx_done_tick) begin
                    w_state_next = S_CHECK;
                end else if (w_timeout) begin
                    w_state_next = STOP_ON_ERROR ? S_DONE : S_NEXT;
                end
            end
            S_CHECK: begin
                w_state_next = (w_mismatch && STOP_ON_ERROR) ? S_DONE : S_NEXT;
            end
            S_NEXT: begin
                w_state_next = w_last ? S_DONE : S_LOAD_A;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand generation, transmit request, timer, model and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_timer   <= '0;
            r_rsp     <= '0;
            r_err     <= '0;
            r_tog     <= 1'b0;
            r_tx_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_err     <= '0;
                        r_timeout <= 1'b0;
                        r_done    <= 1'b0;
                        r_idx     <= '0;
                        r_acc     <= '0;
                        r_a       <= A_SEED;
                        r_b       <= B_SEED;
                        r_busy    <= 1'b1;
                    end
                end
                S_LOAD_A: begin
                    if (!tx_busy) begin
                        r_tx_data <= r_a;
                        r_tog     <= ~r_tog;
                    end
                end
                S_LOAD_B: begin
                    if (!tx_busy) begin
                        r_tx_data <= r_b;
                        r_tog     <= ~r_tog;
                    end
                end
                S_WAIT_B: begin
                    // Timer starts from zero on entry to WAIT_RSP.
                    r_timer <= '0;
                end
                S_WAIT_RSP: begin
                    if (rx_done_tick) begin
                        r_rsp <= rx_data_out;
                    end else if (w_timeout) begin
                        r_err     <= sat_inc(r_err);
                        r_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) r_err <= sat_inc(r_err);
                end
                S_NEXT: begin
                    // Accumulate even after a mismatch/timeout so later pairs stay
                    // aligned with the responder's running sum.
                    r_acc <= r_acc + {32'd0, w_product};
                    r_idx <= r_idx + 8'd1;
                    r_a   <= r_a + A_STEP;
                    r_b   <= r_b + B_STEP;
                end
                default: ;
            endcase

            if ((w_state_next == S_DONE) && (r_state != S_DONE)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign tx_start_transmission = r_tog;
    assign tx_data_in            = r_tx_data;
    assign busy                  = r_busy;
    assign done                  = r_done;
    assign pass                  = r_done && (r_err == 8'd0);
    assign error_count           = r_err;
    assign timeout_seen          = r_timeout;

endmodule

// File: tb/tb_mac_link_initiator.sv
// tb_mac_link_initiator: directed bench with a transmitter model (fixed byte
// time) and a MAC responder model (running sum of received A*B products).
`timescale 1ns/1ps
module tb_mac_link_initiator;

    localparam int BYTE_CYC  = 10;
    localparam int RSP_DELAY = 15;
    localparam int TMO       = 100;

    localparam logic [7:0] EXP_BYTES [6] = '{8'h01, 8'h02, 8'h02, 8'h05, 8'h03, 8'h08};
    localparam logic [7:0] EXP_RSP   [3] = '{8'h00, 8'h02, 8'h0C};

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       tx_start_transmission;
    logic       tx_busy;
    logic [7:0] tx_data_in;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data_out  = 8'h00;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] error_count;
    logic       timeout_seen;

    int checks = 0;
    int errors = 0;

    logic        force_busy = 1'b0;
    logic        model_busy = 1'b0;
    int          run_id     = 0;
    int          seen_id    = 0;
    int          rsp_mode   = 0;   // 0 correct, 1 pair 1 answers 0xFF, 2 silent
    int          byte_n     = 0;
    int          busy_cnt   = 0;
    int          rsp_cnt    = 0;
    int          cyc        = 0;
    logic        last_tog   = 1'b0;
    logic [7:0]  rsp_val    = 8'h00;
    logic [7:0]  a_byte     = 8'h00;
    logic [47:0] m_acc      = '0;
    logic [7:0]  byte_log [64];
    int          tog_cyc  [64];
    logic [7:0]  rsp_log  [32];

    assign tx_busy = model_busy | force_busy;

    mac_link_initiator #(
        .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .tx_start_transmission(tx_start_transmission),
        .tx_busy              (tx_busy),
        .tx_data_in           (tx_data_in),
        .rx_done_tick         (rx_done_tick),
        .rx_data_out          (rx_data_out),
        .busy                 (busy),
        .done                 (done),
        .pass                 (pass),
        .error_count          (error_count),
        .timeout_seen         (timeout_seen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter + responder model, evaluated on the falling edge.
    always @(negedge clk) begin
        if (run_id != seen_id) begin
            seen_id = run_id;
            byte_n  = 0;
            m_acc   = '0;
        end
        if (reset) begin
            last_tog     = tx_start_transmission;
            model_busy   = 1'b0;
            busy_cnt     = 0;
            rsp_cnt      = 0;
            rx_done_tick = 1'b0;
        end else begin
            rx_done_tick = 1'b0;
            if (rsp_cnt != 0) begin
                rsp_cnt = rsp_cnt - 1;
                if (rsp_cnt == 0) begin
                    rx_done_tick = 1'b1;
                    rx_data_out  = rsp_val;
                end
            end
            if (tx_start_transmission !== last_tog) begin
                last_tog = tx_start_transmission;
                if (byte_n < 64) begin
                    byte_log[byte_n] = tx_data_in;
                    tog_cyc[byte_n]  = cyc;
                end
                if ((byte_n % 2) == 0) begin
                    a_byte = tx_data_in;
                end else begin
                    rsp_val = m_acc[7:0];
                    if (rsp_mode == 1 && byte_n == 3) rsp_val = 8'hFF;
                    if (byte_n / 2 < 32) rsp_log[byte_n / 2] = rsp_val;
                    m_acc = m_acc + ({40'd0, a_byte} * {40'd0, tx_data_in});
                    if (rsp_mode != 2) rsp_cnt = RSP_DELAY;
                end
                byte_n     = byte_n + 1;
                model_busy = 1'b1;
                busy_cnt   = BYTE_CYC;
            end else if (busy_cnt != 0) begin
                busy_cnt   = busy_cnt - 1;
                model_busy = (busy_cnt != 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit new_run);
        if (new_run) begin
            run_id++;
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_bytes(input string tag, input int target, input int max_cyc);
        int n = 0;
        while (byte_n < target && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, 32'(byte_n >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_tog"},     32'(tx_start_transmission), 32'd0);
        check({pfx, "_data"},    32'(tx_data_in),            32'd0);
        check({pfx, "_busy"},    32'(busy),                  32'd0);
        check({pfx, "_done"},    32'(done),                  32'd0);
        check({pfx, "_pass"},    32'(pass),                  32'd0);
        check({pfx, "_err"},     32'(error_count),           32'd0);
        check({pfx, "_timeout"}, 32'(timeout_seen),          32'd0);
    endtask

    initial begin
        // Power-up reset.
        reset = 1'b1;
        repeat (3) tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // Correct responder, full 16-pair run; a start mid-run is ignored.
        rsp_mode = 0;
        pulse_start(1'b1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_done_low", 32'(done), 32'd0);
        wait_bytes("t1_six_bytes", 6, 300);
        pulse_start(1'b0);
        wait_done("t1_done", 3000);
        for (int i = 0; i < 6; i++) check($sformatf("t1_byte%0d", i), 32'(byte_log[i]), 32'(EXP_BYTES[i]));
        for (int i = 0; i < 3; i++) check($sformatf("t1_rsp%0d", i), 32'(rsp_log[i]), 32'(EXP_RSP[i]));
        check("t1_byte30", 32'(byte_log[30]), 32'h10);
        check("t1_byte31", 32'(byte_log[31]), 32'h2F);
        check("t1_toggles", 32'(byte_n), 32'd32);
        check("t1_pair_gap", 32'(tog_cyc[2] - tog_cyc[1]), 32'd19);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_err", 32'(error_count), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_timeout", 32'(timeout_seen), 32'd0);

        // Responder answers 0xFF for pair 1 only.
        rsp_mode = 1;
        pulse_start(1'b1);
        wait_done("t2_done", 3000);
        check("t2_err", 32'(error_count), 32'd1);
        check("t2_pass", 32'(pass), 32'd0);
        check("t2_timeout", 32'(timeout_seen), 32'd0);
`ifdef MAC_LINK_STOP_ON_ERROR_EN
        check("t2_toggles", 32'(byte_n), 32'd4);
`else
        check("t2_toggles", 32'(byte_n), 32'd32);
        check("t2_rsp1", 32'(rsp_log[1]), 32'hFF);
        check("t2_rsp2", 32'(rsp_log[2]), 32'h0C);
`endif

        // Silent responder: every pair times out after TMO cycles in WAIT_RSP.
        rsp_mode = 2;
        pulse_start(1'b1);
        wait_done("t3_done", 5000);
        check("t3_timeout", 32'(timeout_seen), 32'd1);
        check("t3_pass", 32'(pass), 32'd0);
`ifdef MAC_LINK_STOP_ON_ERROR_EN
        check("t3_err", 32'(error_count), 32'd1);
        check("t3_toggles", 32'(byte_n), 32'd2);
`else
        check("t3_err", 32'(error_count), 32'd16);
        check("t3_gap01", 32'(tog_cyc[2] - tog_cyc[1]), 32'd113);
        check("t3_gap12", 32'(tog_cyc[4] - tog_cyc[3]), 32'd113);
`endif

        // Transmitter held busy for 50 cycles after start.
        rsp_mode   = 0;
        force_busy = 1'b1;
        pulse_start(1'b1);
        repeat (50) tick();
        check("t4_no_toggle", 32'(byte_n), 32'd0);
        check("t4_tog_level", 32'(tx_start_transmission), 32'd0);
`ifdef MAC_LINK_STOP_ON_ERROR_EN
        check("t4_data_hold", 32'(tx_data_in), 32'h02);
`else
        check("t4_data_hold", 32'(tx_data_in), 32'h2F);
`endif
        force_busy = 1'b0;
        tick();
        check("t4_first_toggle", 32'(byte_n), 32'd1);
        check("t4_tog_high", 32'(tx_start_transmission), 32'd1);
        check("t4_data_a0", 32'(tx_data_in), 32'h01);

        // Reset asserted while waiting for byte B to finish.
        wait_bytes("t5_two_bytes", 2, 100);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("t5_rst");
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("t5_idle_no_toggle", 32'(byte_n), 32'd2);
        check("t5_idle_busy", 32'(busy), 32'd0);
        pulse_start(1'b1);
        wait_done("t5_done", 3000);
        check("t5_byte0", 32'(byte_log[0]), 32'h01);
        check("t5_byte1", 32'(byte_log[1]), 32'h02);
        check("t5_toggles", 32'(byte_n), 32'd32);
        check("t5_pass", 32'(pass), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
